// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
package mult_pkg;

  localparam int unsigned DefAWidth = 8;
  localparam int unsigned DefBWidth = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  // Width of the full unsigned product A*B.
  function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/mult_shift_add_ctrl.sv
// Sequencer for the shift-add multiplier: FSM plus step counter, issuing
// capture/step/finish strobes to the datapath in the top level.
module mult_shift_add_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned B_WIDTH    = DefBWidth,
  parameter bit          EARLY_EXIT = 1'b1,
  parameter int unsigned IW         = $clog2(B_WIDTH + 1)
) (
  input  logic          SYS_CLOCK,
  input  logic          SYS_RESET,
  input  logic          in_valid_i,
  input  logic          out_ready_i,
  input  logic          b_zero_i,
  output logic          in_ready_o,
  output logic          busy_o,
  output logic          out_valid_o,
  output logic [IW-1:0] iter_count_o,
  output logic          capture_o,
  output logic          step_o,
  output logic          finish_o
);

  mult_state_t   state_q;
  logic [IW-1:0] iter_q;
  logic          run_exit;

  // Decode handshake flags and datapath strobes from the registered state.
  always_comb begin
    run_exit     = (EARLY_EXIT && b_zero_i) || (iter_q == IW'(B_WIDTH));
    in_ready_o   = (state_q == IDLE);
    busy_o       = (state_q == RUN);
    out_valid_o  = (state_q == DONE);
    capture_o    = (state_q == IDLE) && in_valid_i;
    step_o       = (state_q == RUN) && !run_exit;
    finish_o     = (state_q == RUN) && run_exit;
    iter_count_o = iter_q;
  end

  // State transitions and step counting; the count persists through DONE and
  // IDLE so the last product's step count stays observable.
  always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q <= RUN;
            iter_q  <= '0;
          end
        end
        RUN: begin
          if (run_exit) begin
            state_q <= DONE;
          end else begin
            iter_q <= iter_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mult_shift_add_unit.sv
// Radix-2 shift-add unsigned multiplier with valid/ready on both sides.
// The control FSM lives in mult_shift_add_ctrl; this level holds the datapath.
module mult_shift_add_unit
  import mult_pkg::*;
#(
  parameter int unsigned A_WIDTH    = DefAWidth,
  parameter int unsigned B_WIDTH    = DefBWidth,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                           SYS_CLOCK,
  input  logic                           SYS_RESET,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic [A_WIDTH-1:0]             A,
  input  logic [B_WIDTH-1:0]             B,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [A_WIDTH+B_WIDTH-1:0]     PRODUCT,
  output logic                           BUSY,
  output logic [$clog2(B_WIDTH+1)-1:0]   ITER_COUNT
);

  localparam int unsigned PW = prod_width(A_WIDTH, B_WIDTH);
  localparam int unsigned IW = $clog2(B_WIDTH + 1);

  logic [PW-1:0]      acc_q;
  logic [PW-1:0]      a_sh_q;
  logic [B_WIDTH-1:0] b_sh_q;
  logic [PW-1:0]      product_q;
  logic               capture;
  logic               step;
  logic               finish;
  logic               b_zero;

  assign b_zero  = (b_sh_q == '0);
  assign PRODUCT = product_q;

  mult_shift_add_ctrl #(
    .B_WIDTH    (B_WIDTH),
    .EARLY_EXIT (EARLY_EXIT),
    .IW         (IW)
  ) u_ctrl (
    .SYS_CLOCK    (SYS_CLOCK),
    .SYS_RESET    (SYS_RESET),
    .in_valid_i   (IN_VALID),
    .out_ready_i  (OUT_READY),
    .b_zero_i     (b_zero),
    .in_ready_o   (IN_READY),
    .busy_o       (BUSY),
    .out_valid_o  (OUT_VALID),
    .iter_count_o (ITER_COUNT),
    .capture_o    (capture),
    .step_o       (step),
    .finish_o     (finish)
  );

  // Operand capture, one add/shift per step, and product latch on finish.
  // Bits of a_sh shifted past the MSB are always zero for any real product.
  always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      acc_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      product_q <= '0;
    end else if (capture) begin
      acc_q  <= '0;
      a_sh_q <= PW'(A);
      b_sh_q <= B;
    end else if (step) begin
      acc_q  <= acc_q + (b_sh_q[0] ? a_sh_q : '0);
      a_sh_q <= a_sh_q << 1;
      b_sh_q <= b_sh_q >> 1;
    end else if (finish) begin
      product_q <= acc_q;
    end
  end

endmodule
